ps2_receiver: RTL and testbench

Parametrised PS/2 device-to-host receiver. It synchronises and deglitches the raw PS/2 clock and data lines, and decodes full 11-bit frames with odd-parity and stop-bit checking. An inter-bit timeout recovers from truncated frames, and accepted bytes are buffered in a FIFO with a valid/ready output. The block sits between the keyboard pins and the terminal's scancode decoder, all in the clk100 domain.

---
 rtl/ps2_pkg.sv | 8 +
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_receiver.sv | 148 ++++++++++++++
 tb/tb_ps2_receiver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
// Frame: start(0), 8 data bits LSB first, odd parity, stop(1).
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam int unsigned PS2_DATA_BITS  = 8;
   localparam int unsigned PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a glitch filter.
// The filtered output flips only after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt
);
   logic       sync1_q, sync2_q;
   logic       filt_q, filt_d;
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == 8'(FILTER_LEN - 1)) filt_d = sync2_q;
         else                              cnt_d  = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign filt = filt_q;
endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: conditioned lines, frame FSM with parity/stop
// checking, inter-bit timeout and an output byte FIFO with valid/ready.
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 200000,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic       clk100,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       err_parity,
   output logic       err_frame,
   output logic       err_timeout,
   output logic       err_overflow
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic clk_filt, data_filt, fall;
   logic clk_prev_q;

   state_t                      state_q, state_d;
   logic [2:0]                  bit_cnt_q, bit_cnt_d;
   logic [PS2_DATA_BITS-1:0]    shift_q, shift_d;
   logic                        parity_q, parity_d;
   logic [TW-1:0]               tmo_q, tmo_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PS2_DATA_BITS-1:0]    mem_q [FIFO_DEPTH];
   logic                        err_parity_q, err_parity_d;
   logic                        err_frame_q, err_frame_d;
   logic                        err_timeout_q, err_timeout_d;
   logic                        err_overflow_q, err_overflow_d;
   logic                        push, pop, full, empty;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk(clk100), .rst(rst), .raw(ps2_clk), .filt(clk_filt)
   );
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk(clk100), .rst(rst), .raw(ps2_data), .filt(data_filt)
   );

   assign fall  = clk_prev_q & ~clk_filt;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      parity_d       = parity_q;
      tmo_d          = tmo_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      err_parity_d   = 1'b0;
      err_frame_d    = 1'b0;
      err_timeout_d  = 1'b0;
      err_overflow_d = 1'b0;
      push           = 1'b0;
      pop            = ~empty & rx_ready;

      if (fall) begin
         case (state_q)
            IDLE: if (!data_filt) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
            DATA: begin
               shift_d   = {data_filt, shift_q[PS2_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
            end
            PARITY: begin
               parity_d = data_filt;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!data_filt)                err_frame_d    = 1'b1;
               else if (!(^shift_q ^ parity_q)) err_parity_d = 1'b1;
               else if (full && !pop)         err_overflow_d = 1'b1;
               else                           push           = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end

      // A fall in the same cycle as expiry wins: the frame is still progressing.
      if (state_q == IDLE || fall) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
         tmo_d         = '0;
         state_d       = IDLE;
         err_timeout_d = 1'b1;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         clk_prev_q     <= 1'b1;
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         parity_q       <= 1'b0;
         tmo_q          <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         err_parity_q   <= 1'b0;
         err_frame_q    <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_overflow_q <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         clk_prev_q     <= clk_filt;
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         parity_q       <= parity_d;
         tmo_q          <= tmo_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         err_parity_q   <= err_parity_d;
         err_frame_q    <= err_frame_d;
         err_timeout_q  <= err_timeout_d;
         err_overflow_q <= err_overflow_d;
         if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
      end
   end

   assign rx_valid     = ~empty;
   assign rx_data      = mem_q[rd_ptr_q[AW-1:0]];
   assign err_parity   = err_parity_q;
   assign err_frame    = err_frame_q;
   assign err_timeout  = err_timeout_q;
   assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver using a fast PS/2 clock (80 clk100 cycles per bit)
// and a shortened timeout so every scenario fits in a short run.
`timescale 1ns/1ps
module tb_ps2_receiver;
   localparam int unsigned FILTER_LEN     = 8;
   localparam int unsigned TIMEOUT_CYCLES = 2000;
   localparam int unsigned FIFO_DEPTH     = 8;

   logic       clk100 = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       err_parity, err_frame, err_timeout, err_overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int n_par = 0, n_frm = 0, n_tmo = 0, n_ovf = 0;

   ps2_receiver #(
      .FILTER_LEN(FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk100(clk100), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .err_parity(err_parity), .err_frame(err_frame),
      .err_timeout(err_timeout), .err_overflow(err_overflow)
   );

   always #5 clk100 = ~clk100;

   // Count cycles each error output is high; a clean pulse contributes exactly 1.
   always @(negedge clk100) begin
      if (err_parity)   n_par++;
      if (err_frame)    n_frm++;
      if (err_timeout)  n_tmo++;
      if (err_overflow) n_ovf++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk100);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par,
                                              input logic stop);
      logic par;
      par = ~(^d) ^ bad_par;
      return {stop, par, d, 1'b0};
   endfunction

   // Sends frame bits lo..hi (bit 0 = start); line idles high afterwards.
   task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ps2_data = f[i];
         wait_cyc(20);
         ps2_clk = 1'b0;
         wait_cyc(40);
         ps2_clk = 1'b1;
         wait_cyc(20);
      end
      ps2_data = 1'b1;
   endtask

   task automatic pop_one;
      rx_ready = 1'b1;
      wait_cyc(1);
      rx_ready = 1'b0;
   endtask

   initial begin
      logic [10:0] f;
      wait_cyc(3);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_errs", {err_parity, err_frame, err_timeout, err_overflow}, 4'b0);
      rst = 1'b0;
      wait_cyc(5);

      // 1: 0x1C, with exact push latency on the stop bit
      f = make_frame(8'h1C, 1'b0, 1'b1);
      check("frame_1c_parity_bit", f[9], 1'b0);
      send_bits(f, 0, 9);
      ps2_data = 1'b1;
      wait_cyc(20);
      ps2_clk = 1'b0;
      wait_cyc(10);
      check("push_latency_before", rx_valid, 0);
      wait_cyc(1);
      check("push_latency_valid", rx_valid, 1);
      check("rx_data_1c", rx_data, 8'h1C);
      wait_cyc(29);
      ps2_clk = 1'b1;
      wait_cyc(20);
      check("rx_data_1c_stable", rx_data, 8'h1C);
      pop_one();
      check("pop_1c_empty", rx_valid, 0);

      // 2: bad parity, then bad stop bit
      send_bits(make_frame(8'h1C, 1'b1, 1'b1), 0, 10);
      wait_cyc(30);
      check("parity_err_pulse", n_par, 1);
      check("parity_no_push", rx_valid, 0);
      send_bits(make_frame(8'h1C, 1'b0, 1'b0), 0, 10);
      wait_cyc(30);
      check("frame_err_pulse", n_frm, 1);
      check("frame_no_push", rx_valid, 0);
      check("frame_no_parity_err", n_par, 1);

      // 3: truncated frame times out, then 0xF0 decodes
      send_bits(make_frame(8'h55, 1'b0, 1'b1), 0, 4);
      wait_cyc(2500);
      check("timeout_pulse", n_tmo, 1);
      check("timeout_no_push", rx_valid, 0);
      send_bits(make_frame(8'hF0, 1'b0, 1'b1), 0, 10);
      wait_cyc(30);
      check("after_timeout_valid", rx_valid, 1);
      check("after_timeout_f0", rx_data, 8'hF0);
      pop_one();

      // 4: overflow on the ninth byte, drain in order
      for (int k = 1; k <= 8; k++) send_bits(make_frame(8'(k), 1'b0, 1'b1), 0, 10);
      wait_cyc(30);
      check("full_no_overflow_yet", n_ovf, 0);
      send_bits(make_frame(8'h09, 1'b0, 1'b1), 0, 10);
      wait_cyc(30);
      check("overflow_pulse", n_ovf, 1);
      for (int k = 1; k <= 8; k++) begin
         check($sformatf("drain_valid_%0d", k), rx_valid, 1);
         check($sformatf("drain_data_%0d", k), rx_data, 32'(k));
         pop_one();
      end
      check("drained_empty", rx_valid, 0);

      // 5: short low glitch on ps2_clk mid-frame is filtered out
      f = make_frame(8'h5A, 1'b0, 1'b1);
      send_bits(f, 0, 4);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
      send_bits(f, 5, 10);
      wait_cyc(30);
      check("glitch_valid", rx_valid, 1);
      check("glitch_data_5a", rx_data, 8'h5A);
      pop_one();

      // 6: reset mid-frame, then a clean 0x29
      send_bits(make_frame(8'hAA, 1'b0, 1'b1), 0, 3);
      ps2_data = 1'b0;
      rst = 1'b1;
      wait_cyc(3);
      ps2_data = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(20);
      send_bits(make_frame(8'h29, 1'b0, 1'b1), 0, 10);
      wait_cyc(30);
      check("post_reset_valid", rx_valid, 1);
      check("post_reset_29", rx_data, 8'h29);
      pop_one();
      check("post_reset_single", rx_valid, 0);
      check("err_totals", {n_par[7:0], n_frm[7:0], n_tmo[7:0], n_ovf[7:0]}, 32'h01010101);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
